// File: rtl/flaf_trig_sched.sv
// Trigonometric functional-link expansion sequencer: time-shares one sin unit to emit sin/cos(k*pi*x), k=1..P_ORDER.
// Optional FLAF_PASS_X_EN: also emits x itself (Q1.15, saturated) as term index 0 ahead of the trig terms.
module flaf_trig_sched #(
  parameter int P_ORDER = 4,
  parameter int SIN_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_in,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [16:0] theta_o,
  input  logic [15:0] sin_i,
  output logic [15:0] term_o,
  output logic [4:0]  term_idx,
  output logic        term_last,
  output logic        term_valid,
  input  logic        term_ready,
  output logic        busy
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_MUL     = 4'd1;
  localparam logic [3:0] S_ISSUE_S = 4'd2;
  localparam logic [3:0] S_WAIT_S  = 4'd3;
  localparam logic [3:0] S_OUT_S   = 4'd4;
  localparam logic [3:0] S_ISSUE_C = 4'd5;
  localparam logic [3:0] S_WAIT_C  = 4'd6;
  localparam logic [3:0] S_OUT_C   = 4'd7;
`ifdef FLAF_PASS_X_EN
  localparam logic [3:0] S_OUT_X   = 4'd8;
`endif

  localparam logic signed [17:0] PIB2 = 18'sh01922;
  localparam logic signed [17:0] PIM2 = 18'sh06487;
  localparam logic [7:0]         LAT_LAST = 8'(SIN_LAT);
  localparam logic [3:0]         K_LAST   = 4'(P_ORDER);

  logic [3:0]         state;
  logic signed [15:0] x_lat;
  logic signed [16:0] base;
  logic signed [16:0] acc;
  logic [3:0]         k;
  logic [7:0]         lat_cnt;

  // One correction step is enough: every sum is bounded by |acc| + PI < 2*PIM2.
  function automatic logic signed [17:0] wrap18(input logic signed [17:0] v);
    if (v >= PIM2)       wrap18 = v - PIM2;
    else if (v <= -PIM2) wrap18 = v + PIM2;
    else                 wrap18 = v;
  endfunction

  // |x| <= 1.0 keeps |x*PI| below 2^26, so a 29-bit product cannot overflow.
  logic signed [28:0] prod;
  logic signed [16:0] base_next;
  logic signed [17:0] cos_ang;
  logic signed [17:0] acc_next;
  logic               unused_bits;

  assign prod      = $signed({{13{x_lat[15]}}, x_lat}) * 29'sd12868;
  assign base_next = prod[28:12];
  assign cos_ang   = wrap18($signed({acc[16], acc}) + PIB2);
  assign acc_next  = wrap18($signed({acc[16], acc}) + $signed({base[16], base}));
  assign unused_bits = ^{prod[11:0], cos_ang[17], acc_next[17]};

`ifdef FLAF_PASS_X_EN
  logic signed [18:0] x_sh;
  logic [15:0]        x_sat;
  assign x_sh  = {x_lat, 3'b000};
  assign x_sat = (x_sh[18:15] == 4'b0000 || x_sh[18:15] == 4'b1111) ? x_sh[15:0]
               : (x_sh[18] ? 16'h8000 : 16'h7FFF);
`endif

  assign x_ready = (state == S_IDLE);
  assign busy    = (state != S_IDLE);

  // NOTE: all state below is registered with non-blocking assignments so every
  // branch sees the pre-edge values of acc/k/base regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      x_lat      <= '0;
      base       <= '0;
      acc        <= '0;
      k          <= '0;
      lat_cnt    <= '0;
      theta_o    <= '0;
      term_o     <= '0;
      term_idx   <= '0;
      term_last  <= 1'b0;
      term_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (x_valid) begin
            x_lat <= x_in;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          base <= base_next;
          acc  <= base_next;
          k    <= 4'd1;
`ifdef FLAF_PASS_X_EN
          term_o     <= x_sat;
          term_idx   <= 5'd0;
          term_last  <= 1'b0;
          term_valid <= 1'b1;
          state      <= S_OUT_X;
`else
          state <= S_ISSUE_S;
`endif
        end
`ifdef FLAF_PASS_X_EN
        S_OUT_X: begin
          if (term_ready) begin
            term_valid <= 1'b0;
            state      <= S_ISSUE_S;
          end
        end
`endif
        S_ISSUE_S: begin
          theta_o <= acc;
          lat_cnt <= '0;
          state   <= S_WAIT_S;
        end
        S_WAIT_S: begin
          if (lat_cnt == LAT_LAST) begin
            term_o     <= sin_i;
            term_idx   <= {k, 1'b0} - 5'd1;
            term_last  <= 1'b0;
            term_valid <= 1'b1;
            state      <= S_OUT_S;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        S_OUT_S: begin
          if (term_ready) begin
            term_valid <= 1'b0;
            state      <= S_ISSUE_C;
          end
        end
        S_ISSUE_C: begin
          theta_o <= cos_ang[16:0];
          lat_cnt <= '0;
          state   <= S_WAIT_C;
        end
        S_WAIT_C: begin
          if (lat_cnt == LAT_LAST) begin
            term_o     <= sin_i;
            term_idx   <= {k, 1'b0};
            term_last  <= (k == K_LAST);
            term_valid <= 1'b1;
            state      <= S_OUT_C;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        S_OUT_C: begin
          if (term_ready) begin
            term_valid <= 1'b0;
            if (k == K_LAST) begin
              state <= S_IDLE;
            end else begin
              acc   <= acc_next[16:0];
              k     <= k + 4'd1;
              state <= S_ISSUE_S;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/flaf_trig_sched.md
Name: flaf_trig_sched

Overview:
Sequences one shared sine-approximation datapath to produce the trigonometric functional-link expansion of an input sample x. The expansion is sin(k·pi·x) and cos(k·pi·x) for k = 1..P_ORDER. The block generates wrapped phase angles, drives them to the sin unit, captures the results and streams the terms to the FLAF weight/filter stage over a valid/ready handshake. Cosine terms reuse the same unit through cos(a) = sin(a + pi/2).

Parameters:
P_ORDER, 4, expansion order; 2·P_ORDER trig terms per sample (legal range 1..15).
SIN_LAT, 0, register stages inside the shared sin unit; result is sampled SIN_LAT+1 edges after theta_o is updated.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
x_in  in  16  signed Q4.12 sample; legal range -0x1000..0x1000 (|x| ≤ 1.0).
x_valid  in  1  x_in valid.
x_ready  out  1  high only in IDLE.
theta_o  out  17  two's-complement Q5.12 angle to the sin unit (bit 16 = sign).
sin_i  in  16  signed Q1.15 result from the sin unit.
term_o  out  16  expansion term, Q1.15.
term_idx  out  5  term index; sin k → 2k-1, cos k → 2k.
term_last  out  1  high with the final term of the sample.
term_valid  out  1  term_o/term_idx/term_last valid.
term_ready  in  1  downstream accepts the term.
busy  out  1  high when not IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE. Clear theta_o, term_o, term_idx, term_last, term_valid, busy and the accumulator. x_ready=1 once reset is released. Reset mid-sample aborts the sample silently; no partial terms survive.
- Constants (Q4.12): PI=0x3244, PIB2=0x1922, PIM2=0x6487.
- State machine:
  - IDLE: wait for x_valid & x_ready. On that edge, latch x_in, go to MUL.
  - MUL (1 cycle): base = (x·PI) >>> 12, signed arithmetic shift (floor). acc = base, k = 1.
  - ISSUE_S: theta_o = acc. Go to WAIT_S.
  - WAIT_S: count SIN_LAT+1 edges. On the last edge, register sin_i into term_o, set idx = 2k-1, term_valid = 1. Go to OUT_S.
  - OUT_S: hold all outputs until term_ready. On accept, go to ISSUE_C.
  - ISSUE_C: theta_o = wrap(acc + PIB2). Go to WAIT_C.
  - WAIT_C: count SIN_LAT+1 edges, then register the result as for WAIT_S.
  - OUT_C: hold until term_ready. On accept:
    - if k = P_ORDER, go to IDLE;
    - else acc = wrap(acc + base), k = k+1, go to ISSUE_S.
- wrap(v), 18-bit signed: if v ≥ PIM2 then v − PIM2; else if v ≤ −PIM2 then v + PIM2; else v. One correction suffices because |base| ≤ PI.
- theta_o is the low 17 bits of the wrapped value and holds its value outside ISSUE/WAIT.
- term_valid may be high in the same cycle term_ready rises; the transfer occurs on that edge. Outputs never change while term_valid=1 & term_ready=0.
- term_last = 1 only on the cos term with k = P_ORDER.
- Throughput (ready always high, SIN_LAT=0): 1 IDLE + 1 MUL + 3 cycles per term. First term is valid 4 cycles after x is accepted.
- x_valid during busy is ignored: no latch, x_ready=0.
- x outside ±0x1000 is undefined use. The bench does not drive it.

Optional Feature:
Macro FLAF_PASS_X_EN.
- Defined: the MUL state also emits x itself as term idx 0, with term_o = x_in<<3 (Q4.12 → Q1.15, saturated to 0x7FFF/0x8000). The next state waits for term_ready before ISSUE_S. Term count becomes 2·P_ORDER+1.
- Undefined: no idx-0 term; MUL goes straight to ISSUE_S.

Test Plan:
- x=0x0000, P_ORDER=4, ready=1 → 8 terms, idx 1..8. theta_o alternates 0x00000 / 0x01922. sin terms ≈0x0000 and cos terms ≈0x7FFF (±0x20). term_last only on idx 8.
- x=0x1000 → k=1: theta_o 0x03244 then 0x04B66. k=2: acc 0x6488 wraps to 0x0001; theta_o 0x00001 then 0x01923.
- x=−0x1000 → theta_o 0x1CDBC (sin), then 0x1E6DE (cos). k=2 sin angle −0x6488 wraps to 0x1FFFF.
- term_ready held low for 5 cycles on idx 3 → term_o/term_idx stable throughout, no theta_o advance. Sequence resumes on release; total terms still 8.
- Assert reset low while in WAIT_C of k=2 → all outputs 0 asynchronously. After release, a new x=0x0800 yields a fresh idx 1 term; no stale terms appear.
- x_valid pulses during busy → ignored. With FLAF_PASS_X_EN, x=0x0800 → idx 0 term_o=0x4000, followed by 8 trig terms.
